// File: rtl/phys_free_list_pkg.sv
// phys_free_list_pkg: shared rename-stage register-file constants and types
package phys_free_list_pkg;
  localparam int PHYS_REG_BITS = 6;
  localparam int ARCH_REG_BITS = 5;
  localparam int NUM_ARCH = 32;
  localparam int FL_DEPTH = (1 << PHYS_REG_BITS) - NUM_ARCH;
  typedef logic [PHYS_REG_BITS-1:0] phys_reg_t;
  typedef logic [ARCH_REG_BITS-1:0] arch_reg_t;
endpackage

// File: rtl/phys_free_list.sv
// phys_free_list: ring-buffer pool of unmapped physical registers with one-cycle flush recovery
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int PHYS_REG_BITS = phys_free_list_pkg::PHYS_REG_BITS,
  parameter int NUM_ARCH = phys_free_list_pkg::NUM_ARCH,
  parameter int DEPTH = phys_free_list_pkg::FL_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_req_i,
  output logic [PHYS_REG_BITS-1:0]   alloc_pd_o,
  output logic                       alloc_valid_o,
  input  logic                       free_we_i,
  input  logic [PHYS_REG_BITS-1:0]   free_pd_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  logic [PHYS_REG_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic deq, enq;
  assign count_o = tail_q - head_q;
  assign full_o = count_o == PW'(DEPTH);
  assign alloc_valid_o = count_o != '0;
  assign alloc_pd_o = mem_q[head_q[IW-1:0]];
  assign deq = alloc_req_i && alloc_valid_o && !flush_i;
  assign enq = free_we_i && free_pd_i != '0 && !full_o;
  // Flush rewinds head to exactly DEPTH entries behind the post-enqueue tail; those slots still hold the speculative pds.
  always_comb begin
    tail_d = tail_q + PW'(enq);
    head_d = flush_i ? {~tail_d[PW-1], tail_d[IW-1:0]} : head_q + PW'(deq);
  end
  // Pointer registers; reset leaves the list full (wrap bits differ, indices equal).
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= PW'(DEPTH);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  // Ring storage: reset loads the registers above the identity-mapped ones, commits write at tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= PHYS_REG_BITS'(NUM_ARCH + i);
    end else if (enq) begin
      mem_q[tail_q[IW-1:0]] <= free_pd_i;
    end
  end
  // A release while full means the pool lost track of a register; flag it in simulation.
  always @(posedge clk) begin
    if (!rst && free_we_i && full_o) assert (1'b0) else $warning("phys_free_list: release of p%0d dropped, list full", free_pd_i);
  end
endmodule
